alu_input_ctrl: RTL and testbench



---
 rtl/alu_input_ctrl_pkg.sv | 28 ++
 rtl/alu_input_ctrl_key_debounce.sv | 74 +++++++
 rtl/alu_input_ctrl.sv | 145 ++++++++++++++
 tb/tb_alu_input_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_input_ctrl_pkg.sv
// Shared definitions for the SimpleALU input front-end: opcode encoding,
// default timing parameters and the operand widening helper.
package alu_input_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_LOAD = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_MUL  = 3'd3,
      OP_AND  = 3'd4,
      OP_OR   = 3'd5,
      OP_XOR  = 3'd6,
      OP_SHL  = 3'd7
   } alu_op_e;

   // 50 MHz board clock -> 1 ms tick
   localparam int DEF_CLK_DIV     = 50000;
   localparam int DEF_DEBOUNCE_MS = 10;

   // Width of the per-key debounce counter
   localparam int DB_CNT_W = 4;

   // The 8-bit operand enters the 16-bit accumulator datapath zero-extended
   function automatic logic [15:0] zext_operand(input logic [7:0] value);
      return {8'h00, value};
   endfunction

endpackage

// File: rtl/alu_input_ctrl_key_debounce.sv
// One push-button: 2-flop synchronizer, tick-based debounce and a one-cycle
// press pulse on the released-to-pressed transition of the debounced level.
module key_debounce
   import alu_input_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic raw_n,
   output logic press
);

   localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_MS - 1);

   logic                sync1_r;
   logic                sync2_r;
   logic                stable_r;
   logic [DB_CNT_W-1:0] cnt_r;
   logic                press_r;
   logic                level_s;
   logic                stable_next_s;
   logic [DB_CNT_W-1:0] cnt_next_s;

   // Synchronize the raw active-low button; reset value is the released level
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= raw_n;
         sync2_r <= sync1_r;
      end
   end

   // 1 = pressed
   assign level_s = ~sync2_r;

   // Debounce next state: only a tick may move the counter or the stable level
   always_comb begin
      stable_next_s = stable_r;
      cnt_next_s    = cnt_r;
      if (tick) begin
         if (level_s == stable_r) begin
            cnt_next_s = {DB_CNT_W{1'b0}};
         end else if (cnt_r == DB_LAST) begin
            stable_next_s = ~stable_r;
            cnt_next_s    = {DB_CNT_W{1'b0}};
         end else begin
            cnt_next_s = cnt_r + DB_CNT_W'(1);
         end
      end else begin
         stable_next_s = stable_r;
         cnt_next_s    = cnt_r;
      end
   end

   // Debounce state plus press pulse, which fires only on the 0->1 flip
   always_ff @(posedge clk) begin
      if (rst) begin
         stable_r <= 1'b0;
         cnt_r    <= {DB_CNT_W{1'b0}};
         press_r  <= 1'b0;
      end else begin
         stable_r <= stable_next_s;
         cnt_r    <= cnt_next_s;
         press_r  <= stable_next_s & ~stable_r;
      end
   end

   assign press = press_r;

endmodule

// File: rtl/alu_input_ctrl.sv
// SimpleALU front-end: 1 ms tick, debounced keys, operand/opcode latches and
// a 16-bit accumulator updated one cycle after each opcode load.
module alu_input_ctrl
   import alu_input_ctrl_pkg::*;
#(
   parameter int CLK_DIV     = DEF_CLK_DIV,
   parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  SW,
   input  logic [1:0]  KEY,
   output logic        oneMsPulse,
   output logic        dispMode,
   output logic [7:0]  OpReg,
   output logic        ShowOpReg,
   output logic [2:0]  OpCode,
   output logic        ShowOpCode,
   output logic [15:0] OpResult
);

   localparam int                TICK_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);

   logic [TICK_W-1:0] tick_cnt_r;
   logic [TICK_W-1:0] tick_cnt_next_s;
   logic              tick_r;
   logic              mode1_r;
   logic              mode2_r;
   logic              press0_s;
   logic              press1_s;
   logic [7:0]        op_reg_r;
   logic              show_op_reg_r;
   logic [2:0]        op_code_r;
   logic              show_op_code_r;
   logic              exec_r;
   logic [15:0]       op_result_r;
   logic [15:0]       operand_s;
   logic [15:0]       product_s;
   logic [15:0]       alu_res_s;
   logic              unused_sw8_s;

   // SW[8] carries no function on this board
   assign unused_sw8_s = SW[8];

   // Free-running divider count, wrapping at CLK_DIV-1
   always_comb begin
      if (tick_cnt_r == TICK_LAST) begin
         tick_cnt_next_s = {TICK_W{1'b0}};
      end else begin
         tick_cnt_next_s = tick_cnt_r + TICK_W'(1);
      end
   end

   // Divider and tick flop; the tick is pre-decoded so it is high while count == CLK_DIV-1
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_r <= {TICK_W{1'b0}};
         tick_r     <= 1'b0;
      end else begin
         tick_cnt_r <= tick_cnt_next_s;
         tick_r     <= (tick_cnt_next_s == TICK_LAST);
      end
   end

   // Display-mode switch goes through a plain 2-flop synchronizer, no debounce
   always_ff @(posedge clk) begin
      if (rst) begin
         mode1_r <= 1'b0;
         mode2_r <= 1'b0;
      end else begin
         mode1_r <= SW[9];
         mode2_r <= mode1_r;
      end
   end

   key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key0 (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick_r),
      .raw_n (KEY[0]),
      .press (press0_s)
   );

   key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key1 (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick_r),
      .raw_n (KEY[1]),
      .press (press1_s)
   );

   // Accumulator ALU over the registered operand and opcode
   always_comb begin
      operand_s = zext_operand(op_reg_r);
      product_s = op_result_r * operand_s;
      alu_res_s = op_result_r;
      case (alu_op_e'(op_code_r))
         OP_LOAD: alu_res_s = operand_s;
         OP_ADD:  alu_res_s = op_result_r + operand_s;
         OP_SUB:  alu_res_s = op_result_r - operand_s;
         OP_MUL:  alu_res_s = product_s;
         OP_AND:  alu_res_s = op_result_r & operand_s;
         OP_OR:   alu_res_s = op_result_r | operand_s;
         OP_XOR:  alu_res_s = op_result_r ^ operand_s;
         OP_SHL:  alu_res_s = op_result_r << op_reg_r[3:0];
         default: alu_res_s = op_result_r;
      endcase
   end

   // Operand/opcode latches with their strobes, then execute one cycle later
   always_ff @(posedge clk) begin
      if (rst) begin
         op_reg_r       <= 8'h00;
         show_op_reg_r  <= 1'b0;
         op_code_r      <= 3'd0;
         show_op_code_r <= 1'b0;
         exec_r         <= 1'b0;
         op_result_r    <= 16'h0000;
      end else begin
         show_op_reg_r  <= press0_s;
         show_op_code_r <= press1_s;
         exec_r         <= press1_s;
         if (press0_s) begin
            op_reg_r <= SW[7:0];
         end
         if (press1_s) begin
            op_code_r <= SW[2:0];
         end
         // exec_r is high alongside ShowOpCode, so the new OpReg/OpCode are already in place
         if (exec_r) begin
            op_result_r <= alu_res_s;
         end
      end
   end

   assign oneMsPulse = tick_r;
   assign dispMode   = mode2_r;
   assign OpReg      = op_reg_r;
   assign ShowOpReg  = show_op_reg_r;
   assign OpCode     = op_code_r;
   assign ShowOpCode = show_op_code_r;
   assign OpResult   = op_result_r;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Self-checking bench for alu_input_ctrl with CLK_DIV=4, DEBOUNCE_MS=3.
module tb_alu_input_ctrl;

   localparam int CLK_DIV = 4;
   localparam int DB_MS   = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  SW  = 10'h000;
   logic [1:0]  KEY = 2'b11;
   logic        oneMsPulse;
   logic        dispMode;
   logic [7:0]  OpReg;
   logic        ShowOpReg;
   logic [2:0]  OpCode;
   logic        ShowOpCode;
   logic [15:0] OpResult;

   int total = 0;
   int bad   = 0;

   logic [7:0]  exp_reg_q[$];
   logic [2:0]  exp_code_q[$];
   logic [15:0] exp_res_q[$];

   int   n_reg_pulse  = 0;
   int   n_code_pulse = 0;
   int   wide_pulse   = 0;
   logic prev_sr      = 1'b0;
   logic prev_sc      = 1'b0;

   always #5 clk = ~clk;

   alu_input_ctrl #(.CLK_DIV(CLK_DIV), .DEBOUNCE_MS(DB_MS)) dut (
      .clk        (clk),
      .rst        (rst),
      .SW         (SW),
      .KEY        (KEY),
      .oneMsPulse (oneMsPulse),
      .dispMode   (dispMode),
      .OpReg      (OpReg),
      .ShowOpReg  (ShowOpReg),
      .OpCode     (OpCode),
      .ShowOpCode (ShowOpCode),
      .OpResult   (OpResult)
   );

   // Pulse counters and width monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (ShowOpReg)  n_reg_pulse++;
      if (ShowOpCode) n_code_pulse++;
      if ((ShowOpReg && prev_sr) || (ShowOpCode && prev_sc)) wide_pulse++;
      prev_sr = ShowOpReg;
      prev_sc = ShowOpCode;
   end

   // Hold keys in mask low for hold_cyc cycles, release, watch rel_cyc more.
   // Every strobe is checked against the scoreboard; results one cycle after ShowOpCode.
   task automatic press_keys(input logic [1:0] mask, input logic [9:0] sw,
                             input int hold_cyc, input int rel_cyc,
                             output int reg_at, output int code_at);
      logic        res_due;
      logic [7:0]  e8;
      logic [2:0]  e3;
      logic [15:0] e16;
      res_due = 1'b0;
      reg_at  = -1;
      code_at = -1;
      @(negedge clk);
      SW  = sw;
      KEY = ~mask;
      for (int i = 0; i < hold_cyc + rel_cyc; i++) begin
         @(posedge clk);
         #1;
         if (res_due) begin
            res_due = 1'b0;
            e16 = (exp_res_q.size() != 0) ? exp_res_q.pop_front() : 16'hxxxx;
            total++;
            if (OpResult !== e16) begin
               bad++;
               $display("FAIL op_result: got %h want %h", OpResult, e16);
            end
         end
         if (ShowOpReg) begin
            if (reg_at < 0) reg_at = i;
            e8 = (exp_reg_q.size() != 0) ? exp_reg_q.pop_front() : 8'hxx;
            total++;
            if (OpReg !== e8) begin
               bad++;
               $display("FAIL op_reg_load: got %h want %h", OpReg, e8);
            end
         end
         if (ShowOpCode) begin
            if (code_at < 0) code_at = i;
            e3 = (exp_code_q.size() != 0) ? exp_code_q.pop_front() : 3'bxxx;
            total++;
            if (OpCode !== e3) begin
               bad++;
               $display("FAIL op_code_load: got %h want %h", OpCode, e3);
            end
            res_due = 1'b1;
         end
         if (i == hold_cyc - 1) KEY = 2'b11;
      end
      total++;
      if (exp_reg_q.size() != 0 || exp_code_q.size() != 0 || exp_res_q.size() != 0) begin
         bad++;
         $display("FAIL missing_event: pending reg=%0d code=%0d res=%0d want 0",
                  exp_reg_q.size(), exp_code_q.size(), exp_res_q.size());
      end
      exp_reg_q.delete();
      exp_code_q.delete();
      exp_res_q.delete();
   endtask

   task automatic test_reset();
      logic exp_tick;
      rst = 1'b1;
      KEY = 2'b11;
      SW  = 10'h000;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({oneMsPulse, dispMode, OpReg, ShowOpReg, OpCode, ShowOpCode, OpResult} !== 31'd0) begin
         bad++;
         $display("FAIL reset_state: got %h want 0",
                  {oneMsPulse, dispMode, OpReg, ShowOpReg, OpCode, ShowOpCode, OpResult});
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         exp_tick = ((i % CLK_DIV) == CLK_DIV - 1);
         total++;
         if (oneMsPulse !== exp_tick) begin
            bad++;
            $display("FAIL tick_phase cycle %0d: got %b want %b", i, oneMsPulse, exp_tick);
         end
         total++;
         if ({dispMode, OpReg, ShowOpReg, OpCode, ShowOpCode, OpResult} !== 30'd0) begin
            bad++;
            $display("FAIL idle_outputs cycle %0d: got %h want 0", i,
                     {dispMode, OpReg, ShowOpReg, OpCode, ShowOpCode, OpResult});
         end
      end
   endtask

   task automatic test_bounce();
      int r0;
      r0 = n_reg_pulse;
      @(negedge clk);
      SW = 10'h0C3;
      for (int k = 0; k < 5; k++) begin
         KEY[0] = 1'b0;
         repeat (CLK_DIV) @(negedge clk);
         KEY[0] = 1'b1;
         repeat (CLK_DIV) @(negedge clk);
      end
      repeat (30) @(negedge clk);
      total++;
      if (n_reg_pulse - r0 !== 0) begin
         bad++;
         $display("FAIL bounce_pulses: got %0d want 0", n_reg_pulse - r0);
      end
      total++;
      if (OpReg !== 8'h00) begin
         bad++;
         $display("FAIL bounce_opreg: got %h want 00", OpReg);
      end
   endtask

   task automatic test_operand_load();
      int r0, ra, rc;
      r0 = n_reg_pulse;
      exp_reg_q.push_back(8'hA5);
      press_keys(2'b01, 10'h0A5, 20 * CLK_DIV, 40, ra, rc);
      total++;
      if (n_reg_pulse - r0 !== 1) begin
         bad++;
         $display("FAIL operand_pulse_count: got %0d want 1", n_reg_pulse - r0);
      end
      total++;
      if (OpReg !== 8'hA5) begin
         bad++;
         $display("FAIL operand_hold: got %h want a5", OpReg);
      end
      total++;
      if (ra < 2 + CLK_DIV * (DB_MS - 1) || ra > 2 + CLK_DIV * (DB_MS + 1) + 1) begin
         bad++;
         $display("FAIL press_latency: got %0d cycles want %0d..%0d", ra,
                  2 + CLK_DIV * (DB_MS - 1), 2 + CLK_DIV * (DB_MS + 1) + 1);
      end
   endtask

   // Load an operand, then run one opcode and expect the given accumulator value
   task automatic run_op(input logic [7:0] opnd, input logic [2:0] opc, input logic [15:0] res);
      int ra, rc;
      exp_reg_q.push_back(opnd);
      press_keys(2'b01, {2'b00, opnd}, 40, 40, ra, rc);
      exp_code_q.push_back(opc);
      exp_res_q.push_back(res);
      press_keys(2'b10, {7'd0, opc}, 40, 40, ra, rc);
      total++;
      if (rc < 0) begin
         bad++;
         $display("FAIL opcode_timeout: got no ShowOpCode want one for op %0d", opc);
      end
   endtask

   task automatic test_alu_sequence();
      run_op(8'hFF, 3'd0, 16'h00FF);
      run_op(8'h01, 3'd1, 16'h0100);
      run_op(8'h02, 3'd2, 16'h00FE);
      run_op(8'h0F, 3'd7, 16'h0000);
   endtask

   task automatic test_wrap_mul();
      run_op(8'h01, 3'd2, 16'hFFFF);
      run_op(8'h10, 3'd3, 16'hFFF0);
   endtask

   task automatic test_simultaneous();
      int ra, rc;
      @(negedge clk);
      SW = 10'h201;
      @(posedge clk);
      #1;
      total++;
      if (dispMode !== 1'b0) begin
         bad++;
         $display("FAIL mode_one_cycle: got %b want 0", dispMode);
      end
      @(posedge clk);
      #1;
      total++;
      if (dispMode !== 1'b1) begin
         bad++;
         $display("FAIL mode_two_cycles: got %b want 1", dispMode);
      end
      exp_reg_q.push_back(8'h01);
      exp_code_q.push_back(3'd1);
      exp_res_q.push_back(16'hFFF1);
      press_keys(2'b11, 10'h201, 40, 40, ra, rc);
      total++;
      if (ra < 0 || ra !== rc) begin
         bad++;
         $display("FAIL simultaneous_strobes: got reg@%0d code@%0d want equal", ra, rc);
      end
   endtask

   task automatic test_reset_mid_exec();
      bit found;
      bit stuck;
      int r0, c0;
      found = 1'b0;
      @(negedge clk);
      SW  = 10'h203;
      KEY = 2'b00;
      for (int i = 0; i < 60 && !found; i++) begin
         @(posedge clk);
         #1;
         if (ShowOpCode) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL exec_timeout: got no ShowOpCode want one within 60 cycles");
      end else begin
         total++;
         if ({OpReg, OpCode} !== {8'h03, 3'd3}) begin
            bad++;
            $display("FAIL pre_reset_latch: got %h/%h want 03/3", OpReg, OpCode);
         end
         rst = 1'b1;
         KEY = 2'b11;
         @(posedge clk);
         #1;
         total++;
         if ({oneMsPulse, dispMode, OpReg, ShowOpReg, OpCode, ShowOpCode, OpResult} !== 31'd0) begin
            bad++;
            $display("FAIL mid_exec_reset: got %h want 0",
                     {oneMsPulse, dispMode, OpReg, ShowOpReg, OpCode, ShowOpCode, OpResult});
         end
         rst = 1'b0;
         r0 = n_reg_pulse;
         c0 = n_code_pulse;
         stuck = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (OpResult !== 16'h0000) stuck = 1'b1;
         end
         total++;
         if (stuck || n_reg_pulse != r0 || n_code_pulse != c0) begin
            bad++;
            $display("FAIL post_reset_quiet: got result %h pulses %0d/%0d want 0000 0/0",
                     OpResult, n_reg_pulse - r0, n_code_pulse - c0);
         end
      end
   endtask

   task automatic test_pulse_width();
      total++;
      if (wide_pulse !== 0) begin
         bad++;
         $display("FAIL pulse_width: got %0d wide strobes want 0", wide_pulse);
      end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_operand_load();
      test_alu_sequence();
      test_wrap_mul();
      test_simultaneous();
      test_reset_mid_exec();
      test_pulse_width();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case a stimulus loop never completes
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
